// File: rtl/dram_cpu_if.sv
// 68040 bus-side initiator for the DRAM controller: decodes DRAM transfer starts,
// splits line transfers into four wrapped beats and returns nTA / nTEA to the CPU.
module dram_cpu_if #(
  parameter logic [3:0] BASE_ADDR = 4'h0,
  parameter int         ADDR_W    = 26,
  parameter int         TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              nTS,
  input  logic              RnW,
  input  logic [1:0]        SIZ,
  input  logic [31:0]       A,
  output logic              nTA,
  output logic              nTEA,
  output logic              busy,
  output logic              dram_req,
  output logic              dram_wr,
  output logic              dram_page,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [3:0]        dram_be,
  input  logic              dram_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_r, state_s;
  logic [7:0]        tcnt_r, tcnt_s;
  logic [1:0]        beat_r, beat_s;
  logic              line_r, line_s;
  logic              nta_s, ntea_s, busy_s, req_s, wr_s, page_s;
  logic [ADDR_W-1:0] addr_s;
  logic [3:0]        be_s;
  logic              hit_s;
  logic              unused_a_s;

  // Byte lanes for a transfer; a misaligned word follows the A[1] rule.
  function automatic logic [3:0] byte_enables(input logic [1:0] siz, input logic [1:0] a_lo);
    logic [3:0] be;
    case (siz)
      2'b01:   be = 4'b1000 >> a_lo;
      2'b10:   be = a_lo[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  assign hit_s      = (nTS == 1'b0) && (A[31:28] == BASE_ADDR);
  assign unused_a_s = ^A;

  // Next-state and next-output logic; nTA/nTEA default to their idle level.
  always_comb begin
    state_s = state_r;
    tcnt_s  = tcnt_r;
    beat_s  = beat_r;
    line_s  = line_r;
    nta_s   = 1'b1;
    ntea_s  = 1'b1;
    busy_s  = busy;
    req_s   = dram_req;
    wr_s    = dram_wr;
    page_s  = dram_page;
    addr_s  = dram_addr;
    be_s    = dram_be;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          state_s = REQ;
          req_s   = 1'b1;
          busy_s  = 1'b1;
          wr_s    = ~RnW;
          page_s  = 1'b0;
          addr_s  = {A[ADDR_W-1:2], 2'b00};
          be_s    = byte_enables(SIZ, A[1:0]);
          line_s  = (SIZ == 2'b11);
          beat_s  = 2'd0;
          tcnt_s  = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // An ack sampled together with expiry still completes the beat.
        if (dram_ack) begin
          req_s   = 1'b0;
          nta_s   = 1'b0;
          state_s = ACK;
        end else if (tcnt_r == TO_LAST) begin
          req_s   = 1'b0;
          ntea_s  = 1'b0;
          busy_s  = 1'b0;
          page_s  = 1'b0;
          state_s = IDLE;
        end else begin
          tcnt_s  = tcnt_r + 8'd1;
        end
      end
      ACK: begin
        if (line_r && (beat_r != 2'd3)) begin
          beat_s      = beat_r + 2'd1;
          addr_s[3:2] = dram_addr[3:2] + 2'd1;
          page_s      = 1'b1;
          req_s       = 1'b1;
          tcnt_s      = 8'd0;
          state_s     = REQ;
        end else begin
          busy_s  = 1'b0;
          page_s  = 1'b0;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        busy_s  = 1'b0;
        page_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_r   <= IDLE;
      tcnt_r    <= 8'd0;
      beat_r    <= 2'd0;
      line_r    <= 1'b0;
      nTA       <= 1'b1;
      nTEA      <= 1'b1;
      busy      <= 1'b0;
      dram_req  <= 1'b0;
      dram_wr   <= 1'b0;
      dram_page <= 1'b0;
      dram_addr <= '0;
      dram_be   <= 4'b0000;
    end else begin
      state_r   <= state_s;
      tcnt_r    <= tcnt_s;
      beat_r    <= beat_s;
      line_r    <= line_s;
      nTA       <= nta_s;
      nTEA      <= ntea_s;
      busy      <= busy_s;
      dram_req  <= req_s;
      dram_wr   <= wr_s;
      dram_page <= page_s;
      dram_addr <= addr_s;
      dram_be   <= be_s;
    end
  end

endmodule

// File: tb/tb_dram_cpu_if.sv
// Directed bench for dram_cpu_if (TIMEOUT=8); inputs change and outputs are sampled on the falling edge.
module tb_dram_cpu_if;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        nTS = 1'b1;
  logic        RnW = 1'b1;
  logic [1:0]  SIZ = 2'b00;
  logic [31:0] A = 32'h0;
  logic        dram_ack = 1'b0;
  logic        nTA, nTEA, busy, dram_req, dram_wr, dram_page;
  logic [25:0] dram_addr;
  logic [3:0]  dram_be;

  int n_checks = 0;
  int n_fail = 0;

  dram_cpu_if #(.BASE_ADDR(4'h0), .ADDR_W(26), .TIMEOUT(8)) dut (
    .clk(clk), .nRESET(nRESET), .nTS(nTS), .RnW(RnW), .SIZ(SIZ), .A(A),
    .nTA(nTA), .nTEA(nTEA), .busy(busy), .dram_req(dram_req), .dram_wr(dram_wr),
    .dram_page(dram_page), .dram_addr(dram_addr), .dram_be(dram_be), .dram_ack(dram_ack)
  );

  always #5 clk = ~clk;

  // Pulse nTS for one cycle; called on a falling edge, returns on the next one.
  task automatic start_xfer(input logic rnw, input logic [1:0] siz, input logic [31:0] addr);
    nTS = 1'b0; RnW = rnw; SIZ = siz; A = addr;
    @(negedge clk);
    nTS = 1'b1;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({nTA, nTEA, busy, dram_req, dram_wr, dram_page} !== 6'b110000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 110000", {nTA, nTEA, busy, dram_req, dram_wr, dram_page});
    end
    n_checks++;
    if ({dram_addr, dram_be} !== 30'h0) begin
      n_fail++; $display("FAIL reset_addr_be: got %h/%b expected 0/0000", dram_addr, dram_be);
    end
    @(negedge clk); nRESET = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_long_read;
    start_xfer(1'b1, 2'b00, 32'h0000_1234);
    n_checks++;
    if ({dram_req, busy, dram_wr, nTA, dram_page} !== 5'b11010 || dram_addr !== 26'h0001234 || dram_be !== 4'b1111) begin
      n_fail++; $display("FAIL long_req: got req/busy/wr/nTA/page=%b addr=%h be=%b expected 11010 0001234 1111",
                         {dram_req, busy, dram_wr, nTA, dram_page}, dram_addr, dram_be);
    end
    @(negedge clk);
    n_checks++;
    if ({dram_req, nTA} !== 2'b11) begin
      n_fail++; $display("FAIL long_hold: got req/nTA=%b expected 11", {dram_req, nTA});
    end
    @(negedge clk); dram_ack = 1'b1;
    @(negedge clk); dram_ack = 1'b0;
    n_checks++;
    if ({nTA, dram_req, busy, nTEA} !== 4'b0011) begin
      n_fail++; $display("FAIL long_ta: got nTA/req/busy/nTEA=%b expected 0011", {nTA, dram_req, busy, nTEA});
    end
    @(negedge clk);
    n_checks++;
    if ({nTA, busy} !== 2'b10) begin
      n_fail++; $display("FAIL long_done: got nTA/busy=%b expected 10", {nTA, busy});
    end
  endtask

  task automatic test_line_write;
    logic [25:0] exp_addr [4] = '{26'h108, 26'h10C, 26'h100, 26'h104};
    logic        exp_page [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int ta_seen = 0;
    start_xfer(1'b0, 2'b11, 32'h0000_0108);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({dram_req, dram_page, dram_wr, nTA, busy} !== {1'b1, exp_page[k], 3'b111} || dram_addr !== exp_addr[k]) begin
        n_fail++; $display("FAIL line_beat%0d: got req/page/wr/nTA/busy=%b addr=%h expected %b addr=%h",
                           k, {dram_req, dram_page, dram_wr, nTA, busy}, dram_addr, {1'b1, exp_page[k], 3'b111}, exp_addr[k]);
      end
      dram_ack = 1'b1;
      @(negedge clk); dram_ack = 1'b0;
      if (nTA == 1'b0) ta_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (ta_seen != 4) begin
      n_fail++; $display("FAIL line_ta_count: got %0d expected 4", ta_seen);
    end
    n_checks++;
    if ({busy, dram_page, dram_req, nTA} !== 4'b0001) begin
      n_fail++; $display("FAIL line_done: got busy/page/req/nTA=%b expected 0001", {busy, dram_page, dram_req, nTA});
    end
  endtask

  task automatic test_byte_enables;
    logic [1:0]  siz [6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [31:0] adr [6] = '{32'h202, 32'h202, 32'h200, 32'h203, 32'h200, 32'h203};
    logic [3:0]  exp [6] = '{4'b0010, 4'b0011, 4'b1000, 4'b0001, 4'b1100, 4'b0011};
    for (int i = 0; i < 6; i++) begin
      start_xfer(1'b0, siz[i], adr[i]);
      n_checks++;
      if (dram_be !== exp[i] || dram_addr !== 26'h200) begin
        n_fail++; $display("FAIL be_%0d: got be=%b addr=%h expected be=%b addr=0000200", i, dram_be, dram_addr, exp[i]);
      end
      dram_ack = 1'b1;
      @(negedge clk); dram_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int ta_seen = 0;
    start_xfer(1'b1, 2'b00, 32'h0000_0040);
    for (int k = 1; k <= 8; k++) begin
      if (dram_req == 1'b1 && nTEA == 1'b1) req_cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (req_cycles != 8) begin
      n_fail++; $display("FAIL to_req_cycles: got %0d expected 8", req_cycles);
    end
    n_checks++;
    if ({dram_req, nTEA, nTA, busy} !== 4'b0010) begin
      n_fail++; $display("FAIL to_tea: got req/nTEA/nTA/busy=%b expected 0010", {dram_req, nTEA, nTA, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({nTEA, nTA, dram_req} !== 3'b110) begin
      n_fail++; $display("FAIL to_after: got nTEA/nTA/req=%b expected 110", {nTEA, nTA, dram_req});
    end
    // Ack arriving in the eighth REQ cycle beats the expiry.
    start_xfer(1'b1, 2'b00, 32'h0000_0040);
    for (int k = 1; k < 8; k++) begin
      if (nTA == 1'b0) ta_seen++;
      @(negedge clk);
    end
    dram_ack = 1'b1;
    @(negedge clk); dram_ack = 1'b0;
    n_checks++;
    if ({nTA, nTEA, dram_req, ta_seen[0]} !== 4'b0100) begin
      n_fail++; $display("FAIL to_ack_wins: got nTA/nTEA/req/early=%b expected 0100", {nTA, nTEA, dram_req, ta_seen[0]});
    end
    @(negedge clk);
    n_checks++;
    if ({nTA, nTEA, busy} !== 3'b110) begin
      n_fail++; $display("FAIL to_ack_done: got nTA/nTEA/busy=%b expected 110", {nTA, nTEA, busy});
    end
  endtask

  task automatic test_ignored;
    start_xfer(1'b1, 2'b00, 32'hF000_0010);
    n_checks++;
    if ({dram_req, busy} !== 2'b00) begin
      n_fail++; $display("FAIL nodecode: got req/busy=%b expected 00", {dram_req, busy});
    end
    dram_ack = 1'b1;
    @(negedge clk); dram_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({nTA, nTEA, busy} !== 3'b110) begin
      n_fail++; $display("FAIL stray_ack: got nTA/nTEA/busy=%b expected 110", {nTA, nTEA, busy});
    end
    // A second nTS during a transfer must not restart it.
    start_xfer(1'b1, 2'b00, 32'h0000_0500);
    start_xfer(1'b0, 2'b11, 32'h0000_0900);
    n_checks++;
    if ({dram_req, dram_wr} !== 2'b10 || dram_addr !== 26'h500) begin
      n_fail++; $display("FAIL busy_nts: got req/wr=%b addr=%h expected 10 addr=0000500", {dram_req, dram_wr}, dram_addr);
    end
    dram_ack = 1'b1;
    @(negedge clk); dram_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, dram_req} !== 2'b00) begin
      n_fail++; $display("FAIL busy_nts_done: got busy/req=%b expected 00", {busy, dram_req});
    end
  endtask

  task automatic test_reset_mid_burst;
    start_xfer(1'b0, 2'b11, 32'h0000_0208);
    dram_ack = 1'b1;
    @(negedge clk); dram_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dram_req, dram_page} !== 2'b11 || dram_addr !== 26'h20C) begin
      n_fail++; $display("FAIL mid_beat2: got req/page=%b addr=%h expected 11 addr=000020C", {dram_req, dram_page}, dram_addr);
    end
    nRESET = 1'b0;
    #1;
    n_checks++;
    if ({nTA, nTEA, busy, dram_req, dram_wr, dram_page} !== 6'b110000 || {dram_addr, dram_be} !== 30'h0) begin
      n_fail++; $display("FAIL async_reset: got ctrl=%b addr=%h be=%b expected 110000 0 0000",
                         {nTA, nTEA, busy, dram_req, dram_wr, dram_page}, dram_addr, dram_be);
    end
    @(negedge clk); nRESET = 1'b1;
    dram_ack = 1'b1;
    @(negedge clk); dram_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({nTA, busy, dram_req} !== 3'b100) begin
      n_fail++; $display("FAIL after_reset: got nTA/busy/req=%b expected 100", {nTA, busy, dram_req});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_long_read;
    test_line_write;
    test_byte_enables;
    test_timeout;
    test_ignored;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
